// File: rtl/mem_rowbuf.sv
// Row-buffered memory: one open row absorbs partial-width reads/writes,
// dirty rows are written back on a buffer miss or an explicit flush.
module mem_rowbuf #(
  parameter int ROW_ADDR_WIDTH = 4,
  parameter int ROW_WIDTH = 64,
  parameter int TX_DATA_WIDTH = 16,
  localparam int COL_ADDR_WIDTH = $clog2(ROW_WIDTH / TX_DATA_WIDTH)
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic                      write_en,
  input  logic                      read_en,
  input  logic                      flush,
  input  logic [ROW_ADDR_WIDTH-1:0] row_addr_in,
  input  logic [COL_ADDR_WIDTH-1:0] col_addr_in,
  input  logic [TX_DATA_WIDTH-1:0]  partial_vec_in,
  output logic [TX_DATA_WIDTH-1:0]  partial_vec_out,
  output logic                      ack,
  output logic                      busy
);

  localparam int ROWS = 1 << ROW_ADDR_WIDTH;

  typedef enum logic [2:0] {
    IDLE, WB, FETCH, LOAD, RESP
  } state_t;

  typedef enum logic [1:0] {
    OP_RD, OP_WR, OP_FL
  } op_t;

  logic [ROW_WIDTH-1:0]      mem [ROWS];
  logic [ROW_WIDTH-1:0]      rd_q;

  state_t                    state;
  op_t                       op;
  logic [ROW_ADDR_WIDTH-1:0] req_row;
  logic [COL_ADDR_WIDTH-1:0] req_col;
  logic [TX_DATA_WIDTH-1:0]  req_data;

  logic [ROW_WIDTH-1:0]      buf_data;
  logic [ROW_ADDR_WIDTH-1:0] buf_row;
  logic                      buf_valid;
  logic                      buf_mod;
  logic [ROWS-1:0]           dirty;
  logic                      armed;

  op_t                       cur_op;
  logic [ROW_ADDR_WIDTH-1:0] cur_row;
  logic [COL_ADDR_WIDTH-1:0] cur_col;
  logic [TX_DATA_WIDTH-1:0]  cur_data;
  logic                      req_any;
  logic                      hit;
  logic                      finish;
  logic [ROW_WIDTH-1:0]      fill;
  logic [ROW_WIDTH-1:0]      merged;
  logic [TX_DATA_WIDTH-1:0]  slice;

  // In IDLE the live inputs drive the datapath so a hit completes
  // on its sample edge; afterwards the latched request is used.
  always_comb begin
    cur_op   = op;
    cur_row  = req_row;
    cur_col  = req_col;
    cur_data = req_data;
    if (state == IDLE) begin
      cur_op   = flush ? OP_FL : (write_en ? OP_WR : OP_RD);
      cur_row  = row_addr_in;
      cur_col  = col_addr_in;
      cur_data = partial_vec_in;
    end
  end

  assign req_any = flush | write_en | read_en;
  assign hit = buf_valid && (buf_row == cur_row);

  assign fill = (state == LOAD)
              ? (dirty[cur_row] ? rd_q : '0)
              : buf_data;

  always_comb begin
    merged = fill;
    merged[int'(cur_col)*TX_DATA_WIDTH +: TX_DATA_WIDTH] = cur_data;
  end

  assign slice =
    fill[int'(cur_col)*TX_DATA_WIDTH +: TX_DATA_WIDTH];

  assign finish = (state == LOAD)
               || (state == IDLE && armed && req_any
                   && cur_op != OP_FL && hit);

  always_ff @(posedge clock) begin
    if (state == WB) mem[buf_row] <= buf_data;
    rd_q <= mem[cur_row];
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state           <= IDLE;
      op              <= OP_RD;
      req_row         <= '0;
      req_col         <= '0;
      req_data        <= '0;
      buf_data        <= '0;
      buf_row         <= '0;
      buf_valid       <= 1'b0;
      buf_mod         <= 1'b0;
      dirty           <= '0;
      armed           <= 1'b0;
      ack             <= 1'b0;
      busy            <= 1'b0;
      partial_vec_out <= '0;
    end else begin
      armed <= 1'b1;
      ack   <= 1'b0;
      unique case (state)
        IDLE: begin
          if (armed && req_any) begin
            busy     <= 1'b1;
            op       <= cur_op;
            req_row  <= cur_row;
            req_col  <= cur_col;
            req_data <= cur_data;
            if (cur_op == OP_FL) begin
              state <= buf_mod ? WB : RESP;
              ack   <= !buf_mod;
            end else if (!hit) begin
              state <= buf_mod ? WB : FETCH;
            end
          end
        end
        WB: begin
          buf_mod <= 1'b0;
          if (op == OP_FL) begin
            state <= RESP;
            ack   <= 1'b1;
          end else begin
            state <= FETCH;
          end
        end
        FETCH: state <= LOAD;
        LOAD: begin
          buf_valid <= 1'b1;
          buf_row   <= cur_row;
          buf_mod   <= 1'b0;
        end
        RESP: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
        default: state <= IDLE;
      endcase
      if (finish) begin
        state <= RESP;
        ack   <= 1'b1;
        if (cur_op == OP_WR) begin
          buf_data       <= merged;
          buf_mod        <= 1'b1;
          dirty[cur_row] <= 1'b1;
        end else begin
          buf_data        <= fill;
          partial_vec_out <= slice;
        end
      end
    end
  end

endmodule

// File: tb/tb_mem_rowbuf.sv
// Directed + randomized bench for mem_rowbuf against a logical
// row memory and an abstract open-row latency model.
module tb_mem_rowbuf;

  logic        clock;
  logic        reset;
  logic        write_en;
  logic        read_en;
  logic        flush;
  logic [3:0]  row_addr_in;
  logic [1:0]  col_addr_in;
  logic [15:0] partial_vec_in;
  logic [15:0] partial_vec_out;
  logic        ack;
  logic        busy;

  mem_rowbuf dut (
    .clock(clock),
    .reset(reset),
    .write_en(write_en),
    .read_en(read_en),
    .flush(flush),
    .row_addr_in(row_addr_in),
    .col_addr_in(col_addr_in),
    .partial_vec_in(partial_vec_in),
    .partial_vec_out(partial_vec_out),
    .ack(ack),
    .busy(busy)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int checks = 0;
  int failures = 0;

  logic [63:0] lmem [16];
  logic [15:0] last_rd;
  bit          mv;
  bit          mm;
  int          mr;

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Cycles from sample edge to ack under open-row semantics.
  function automatic int model_lat(input int op, input int row);
    int l;
    if (op == 2) begin
      l = mm ? 2 : 1;
      mm = 0;
      return l;
    end
    if (mv && mr == row) l = 1;
    else begin
      l = mm ? 4 : 3;
      mv = 1;
      mr = row;
      mm = 0;
    end
    if (op == 1) mm = 1;
    return l;
  endfunction

  task automatic model_reset();
    mv = 0;
    mm = 0;
    mr = 0;
    last_rd = '0;
    for (int i = 0; i < 16; i++) lmem[i] = '0;
  endtask

  task automatic clear_in();
    write_en = 0;
    read_en = 0;
    flush = 0;
  endtask

  task automatic wait_ack(input int exp_lat, input string tag);
    int n;
    bit busy_ok;
    n = 0;
    busy_ok = 1;
    while (n < 20) begin
      @(posedge clock);
      #1;
      n++;
      if (busy !== 1'b1) busy_ok = 0;
      if (ack === 1'b1) break;
    end
    chk({tag, " lat"}, 64'(n), 64'(exp_lat));
    chk({tag, " busy"}, 64'(busy_ok), 64'd1);
  endtask

  task automatic post_ack(input string tag);
    @(posedge clock);
    #1;
    chk({tag, " ack_drop"}, 64'(ack), 64'd0);
    chk({tag, " busy_drop"}, 64'(busy), 64'd0);
    chk({tag, " hold"}, 64'(partial_vec_out), 64'(last_rd));
  endtask

  task automatic req(input int op, input int row, input int col,
                     input logic [15:0] d, input bit pre_arm,
                     input string tag);
    int lat;
    lat = model_lat(op, row);
    if (op == 1) lmem[row][col*16 +: 16] = d;
    if (op == 0) last_rd = lmem[row][col*16 +: 16];
    read_en = (op == 0);
    write_en = (op == 1);
    flush = (op == 2);
    row_addr_in = 4'(row);
    col_addr_in = 2'(col);
    partial_vec_in = d;
    if (pre_arm) begin
      @(posedge clock);
      #1;
      chk({tag, " not_sampled"}, 64'({ack, busy}), 64'd0);
    end
    wait_ack(lat, tag);
    if (op == 0) chk({tag, " data"}, 64'(partial_vec_out), 64'(last_rd));
    clear_in();
    post_ack(tag);
  endtask

  task automatic do_reset(input bit arm);
    reset = 0;
    @(posedge clock);
    #1;
    chk("rst ack", 64'(ack), 64'd0);
    chk("rst busy", 64'(busy), 64'd0);
    chk("rst pvo", 64'(partial_vec_out), 64'd0);
    @(posedge clock);
    #1;
    reset = 1;
    model_reset();
    if (arm) begin
      @(posedge clock);
      #1;
    end
  endtask

  initial begin
    int op;
    int lat;
    clear_in();
    row_addr_in = '0;
    col_addr_in = '0;
    partial_vec_in = '0;
    reset = 1;
    #2;
    do_reset(1);

    // Give array row 1 nonzero content, then forget it via reset.
    req(1, 1, 2, 16'hBEEF, 0, "pre_wr");
    req(2, 0, 0, 16'h0, 0, "pre_fl");
    chk("pre_mem1", dut.mem[1], 64'h0000_BEEF_0000_0000);
    do_reset(1);

    req(1, 0, 0, 16'd134, 0, "wr00");
    req(0, 0, 0, 16'h0, 0, "rd00");
    req(0, 0, 3, 16'h0, 0, "rd03");
    req(0, 1, 2, 16'h0, 0, "rd12");

    req(1, 4, 1, 16'd177, 0, "wr41");
    req(0, 5, 0, 16'h0, 0, "rd50");
    req(0, 4, 1, 16'h0, 0, "rd41");

    req(1, 2, 0, 16'hAAAA, 0, "wr20");
    req(1, 2, 3, 16'h5555, 0, "wr23");
    req(2, 0, 0, 16'h0, 0, "fl1");
    chk("fl_mem2", dut.mem[2], 64'h5555_0000_0000_AAAA);
    req(2, 0, 0, 16'h0, 0, "fl2");

    // Simultaneous write and read to the same slice.
    lat = model_lat(1, 3);
    lmem[3][2*16 +: 16] = 16'h1234;
    write_en = 1;
    read_en = 1;
    row_addr_in = 4'd3;
    col_addr_in = 2'd2;
    partial_vec_in = 16'h1234;
    wait_ack(lat, "both_wr");
    write_en = 0;
    post_ack("both_wr");
    lat = model_lat(0, 3);
    last_rd = 16'h1234;
    wait_ack(lat, "both_rd");
    chk("both_rd data", 64'(partial_vec_out), 64'h1234);
    clear_in();
    post_ack("both_rd");

    // Reset in the middle of a writeback of row 4.
    req(1, 4, 1, 16'd177, 0, "wr41b");
    read_en = 1;
    row_addr_in = 4'd5;
    col_addr_in = 2'd0;
    @(posedge clock);
    #1;
    chk("wb busy", 64'(busy), 64'd1);
    #2;
    reset = 0;
    #1;
    chk("mid_rst ack", 64'(ack), 64'd0);
    chk("mid_rst busy", 64'(busy), 64'd0);
    for (int i = 0; i < 2; i++) begin
      @(posedge clock);
      #1;
      chk("in_rst", 64'({ack, busy}), 64'd0);
    end
    clear_in();
    reset = 1;
    model_reset();
    req(0, 4, 1, 16'h0, 1, "rst_rd41");

    for (int i = 0; i < 80; i++) begin
      op = $urandom_range(0, 19);
      if (op == 0) begin
        do_reset(1);
      end else begin
        op = (op < 10) ? 0 : (op < 17) ? 1 : 2;
        req(op, $urandom_range(0, 15), $urandom_range(0, 3),
            16'($urandom), 0, "rnd");
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
